// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter: four writers, up to BURST words per grant into one FIFO; grant chosen in IDLE, first ack one cycle later.
// Writes are combinational while granted; fifo_full stalls the burst in place, and a one-cycle IDLE gap separates grants.
module fifo_wr_arbiter #(
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] din,
   output logic [3:0]      ack,
   input  logic            fifo_full,
   output logic            fifo_wr_en,
   output logic [DW-1:0]   fifo_din,
   output logic [1:0]      grant_id,
   output logic            busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] BURST_LEN = 4'(BURST);

   state_t     state_q, state_d;
   logic [1:0] grant_id_q, grant_id_d;
   logic [1:0] last_q, last_d;
   logic [3:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;

   logic [DW-1:0] lane [4];
   logic [1:0]    pick;
   logic          accept;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane[i] = din[i*DW +: DW];
      end
   end

   // Walk offsets 4..1 from last so the nearest requester after last wins.
   always_comb begin
      pick = last_q;
      for (int k = 4; k >= 1; k--) begin
         if (req[last_q + 2'(k)]) begin
            pick = last_q + 2'(k);
         end
      end
   end

   assign accept = (state_q == GRANT) && req[grant_id_q] && !fifo_full;

   always_comb begin
      ack = 4'b0000;
      if (accept) begin
         ack[grant_id_q] = 1'b1;
      end
      fifo_din = (state_q == GRANT) ? lane[grant_id_q] : '0;
   end

   assign fifo_wr_en = accept;
   assign grant_id   = grant_id_q;
   assign busy       = busy_q;

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (req != 4'b0000) begin
               state_d    = GRANT;
               grant_id_d = pick;
               cnt_d      = 4'd0;
            end
         end
         GRANT: begin
            if (accept) begin
               cnt_d = cnt_q + 4'd1;
            end
            // Requester withdrawal ends the grant even if words remain in the burst.
            if (!req[grant_id_q] || (accept && cnt_d == BURST_LEN)) begin
               state_d = IDLE;
               last_d  = grant_id_q;
            end
         end
      endcase
      busy_d = (state_d == GRANT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         grant_id_q <= 2'd0;
         last_q     <= 2'd3;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;
   localparam int DW    = 8;
   localparam int BURST = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [4*DW-1:0] din;
   logic [3:0]      ack;
   logic            fifo_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_din;
   logic [1:0]      grant_id;
   logic            busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.DW(DW), .BURST(BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din        (din),
      .ack        (ack),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   // Requester i presents base[i] + number of its words already transferred.
   logic [DW-1:0] base     [4];
   logic [DW-1:0] seq      [4];
   logic [DW-1:0] lane_val [4];
   logic          seq_clr;
   logic          mon_en = 1'b0;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_val[i] = base[i] + seq[i];
      end
   end
   assign din = {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};

   // Behavioural model: owner, words still allowed in this burst, last served lane.
   bit m_busy = 1'b0;
   int m_gid  = 0;
   int m_last = 3;
   int m_left = 0;

   logic          e_acc;
   logic [3:0]    e_ack;
   logic [DW-1:0] e_din;

   always_comb begin
      e_acc = m_busy && (req[m_gid] === 1'b1) && (fifo_full === 1'b0);
      e_ack = e_acc ? 4'(1 << m_gid) : 4'b0000;
      e_din = m_busy ? lane_val[m_gid] : '0;
   end

   function automatic int rr_next(int last, logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4] === 1'b1) return (last + k) % 4;
      end
      return last;
   endfunction

   always @(posedge clk) begin
      if (seq_clr === 1'b1) begin
         for (int i = 0; i < 4; i++) seq[i] <= '0;
      end else if (e_acc) begin
         seq[m_gid] <= seq[m_gid] + 1'b1;
      end
      if (rst !== 1'b1) begin
         m_busy <= 1'b0;
         m_gid  <= 0;
         m_last <= 3;
         m_left <= 0;
      end else if (!m_busy) begin
         if (req != 4'b0000) begin
            m_busy <= 1'b1;
            m_gid  <= rr_next(m_last, req);
            m_left <= BURST;
         end
      end else begin
         if (e_acc) m_left <= m_left - 1;
         if (req[m_gid] !== 1'b1 || (e_acc && m_left == 1)) begin
            m_busy <= 1'b0;
            m_last <= m_gid;
         end
      end
   end

   // Scoreboard over every cycle: model agreement, write safety, one-hot ack, per-lane word order.
   int            sb_bad    = 0;
   int            sb_cycles = 0;
   int            wr_cnt [4];
   time           f_t;
   logic [3:0]    f_ack, f_eack;
   logic [DW-1:0] f_din, f_edin;

   function automatic int lane_of(logic [3:0] a);
      for (int i = 0; i < 4; i++) begin
         if (a[i] === 1'b1) return i;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (seq_clr === 1'b1) begin
         for (int i = 0; i < 4; i++) wr_cnt[i] <= 0;
      end else if (mon_en) begin
         sb_cycles <= sb_cycles + 1;
         if (busy !== m_busy || ack !== e_ack || fifo_wr_en !== e_acc || fifo_din !== e_din
             || (m_busy && grant_id !== 2'(m_gid))
             || (fifo_wr_en === 1'b1 && fifo_full === 1'b1)
             || $countones(ack) > 1
             || (fifo_wr_en === 1'b1 && fifo_din !== 8'(base[lane_of(ack)] + 8'(wr_cnt[lane_of(ack)])))) begin
            if (sb_bad == 0) begin
               f_t    <= $time;
               f_ack  <= ack;
               f_eack <= e_ack;
               f_din  <= fifo_din;
               f_edin <= e_din;
            end
            sb_bad <= sb_bad + 1;
         end
         if (fifo_wr_en === 1'b1) wr_cnt[lane_of(ack)] <= wr_cnt[lane_of(ack)] + 1;
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0; req = 4'b0000; fifo_full = 1'b0; seq_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1; seq_clr = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; req = 4'b1111; fifo_full = 1'b0; seq_clr = 1'b1;
      next_cycle();
      mon_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            req = 4'($urandom_range(0, 15));
            fifo_full = 1'($urandom_range(0, 1));
         end else begin
            rst = 1'b1; seq_clr = 1'b0; req = 4'b0000; fifo_full = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d: got %b want 0", c, busy); end
         checks++;
         if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack c=%0d: got %b want 0000", c, ack); end
         checks++;
         if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en c=%0d: got %b want 0", c, fifo_wr_en); end
         checks++;
         if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din c=%0d: got %h want 00", c, fifo_din); end
         checks++;
         if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id c=%0d: got %0d want 0", c, grant_id); end
         next_cycle();
      end
   endtask

   task automatic test_single_burst;
      bit act;
      do_reset();
      base[0] = 8'h11;
      req = 4'b0001;
      for (int c = 0; c <= 5; c++) begin
         act = (c >= 1 && c <= 4);
         @(negedge clk);
         checks++;
         if (busy !== act) begin errors++; $display("FAIL single_busy c=%0d: got %b want %b", c, busy, act); end
         checks++;
         if (ack !== (act ? 4'b0001 : 4'b0000)) begin
            errors++; $display("FAIL single_ack c=%0d: got %b want %b", c, ack, act ? 4'b0001 : 4'b0000);
         end
         if (act) begin
            checks++;
            if (fifo_din !== 8'(8'h11 + c - 1)) begin
               errors++; $display("FAIL single_din c=%0d: got %h want %h", c, fifo_din, 8'(8'h11 + c - 1));
            end
         end
         next_cycle();
      end
      req = 4'b0000;
   endtask

   task automatic test_round_robin;
      int writes;
      int idles;
      int order[$];
      bit prev;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) base[i] = 8'(i * 64);
      req = 4'b1111; writes = 0; idles = 0; prev = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (fifo_wr_en === 1'b1) writes++;
         if (busy !== 1'b1) idles++;
         if (busy === 1'b1 && !prev) order.push_back(int'(grant_id));
         prev = (busy === 1'b1);
         checks++;
         if (busy !== ((c % (BURST + 1)) != 0)) begin
            errors++; $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, (c % (BURST + 1)) != 0);
         end
         next_cycle();
      end
      req = 4'b0000;
      checks++;
      if (writes != 20) begin errors++; $display("FAIL rr_writes: got %0d want 20", writes); end
      checks++;
      if (idles != 5) begin errors++; $display("FAIL rr_idle_cycles: got %0d want 5", idles); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (order.size() <= k) begin
            errors++; $display("FAIL rr_order[%0d]: got none want %0d", k, exp_order[k]);
         end else if (order[k] != exp_order[k]) begin
            errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
         end
      end
   endtask

   task automatic test_stall;
      bit act;
      int k;
      do_reset();
      base[2] = 8'hA0;
      req = 4'b0100; k = 0;
      for (int c = 0; c <= 8; c++) begin
         fifo_full = (c >= 3 && c <= 5);
         act = (c == 1 || c == 2 || c == 6 || c == 7);
         @(negedge clk);
         checks++;
         if (ack !== (act ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL stall_ack c=%0d: got %b want %b", c, ack, act ? 4'b0100 : 4'b0000);
         end
         checks++;
         if (fifo_wr_en !== act) begin errors++; $display("FAIL stall_wr_en c=%0d: got %b want %b", c, fifo_wr_en, act); end
         if (act) begin
            checks++;
            if (fifo_din !== 8'(8'hA0 + k)) begin
               errors++; $display("FAIL stall_din c=%0d: got %h want %h", c, fifo_din, 8'(8'hA0 + k));
            end
            k++;
         end
         if (c >= 3 && c <= 5) begin
            checks++;
            if (busy !== 1'b1 || grant_id !== 2'd2) begin
               errors++; $display("FAIL stall_hold c=%0d: got busy=%b gid=%0d want busy=1 gid=2", c, busy, grant_id);
            end
         end
         if (c == 8) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL stall_exit: got busy=%b want 0", busy); end
         end
         next_cycle();
      end
      fifo_full = 1'b0; req = 4'b0000;
   endtask

   task automatic test_early_drop;
      do_reset();
      base[1] = 8'h50; base[3] = 8'h70;
      req = 4'b0010;
      next_cycle();
      @(negedge clk);
      checks++;
      if (ack !== 4'b0010 || fifo_din !== 8'h50) begin
         errors++; $display("FAIL drop_first: got ack=%b din=%h want ack=0010 din=50", ack, fifo_din);
      end
      next_cycle();
      req = 4'b1001;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ack !== 4'b0000) begin
         errors++; $display("FAIL drop_noack: got busy=%b ack=%b want busy=1 ack=0000", busy, ack);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd3) begin
         errors++; $display("FAIL drop_next_grant: got busy=%b gid=%0d want busy=1 gid=3", busy, grant_id);
      end
      checks++;
      if (ack !== 4'b1000 || fifo_din !== 8'h70) begin
         errors++; $display("FAIL drop_next_word: got ack=%b din=%h want ack=1000 din=70", ack, fifo_din);
      end
      next_cycle();
      req = 4'b0000;
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      base[0] = 8'h30;
      req = 4'b0001;
      repeat (3) next_cycle();
      rst = 1'b0;
      @(negedge clk);
      // Reset only acts at the edge, so the word presented in this cycle still transfers.
      checks++;
      if (ack !== 4'b0001 || fifo_din !== 8'h32) begin
         errors++; $display("FAIL rstmid_third: got ack=%b din=%h want ack=0001 din=32", ack, fifo_din);
      end
      next_cycle();
      req = 4'b0011;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0000 || fifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL rstmid_abort: got busy=%b ack=%b wr=%b want 0/0000/0", busy, ack, fifo_wr_en);
      end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_release_idle: got busy=%b want 0", busy); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd0) begin
         errors++; $display("FAIL rstmid_regrant: got busy=%b gid=%0d want busy=1 gid=0", busy, grant_id);
      end
      checks++;
      if (ack !== 4'b0001 || fifo_din !== 8'h33) begin
         errors++; $display("FAIL rstmid_resume: got ack=%b din=%h want ack=0001 din=33", ack, fifo_din);
      end
      next_cycle();
      req = 4'b0000;
   endtask

   task automatic test_random;
      do_reset();
      for (int i = 0; i < 4; i++) base[i] = 8'(i * 64 + 5);
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (req[i] === 1'b1) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
            end
         end
         fifo_full = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 99) != 0);
         @(negedge clk);
         checks++;
         if (fifo_wr_en === 1'b1 && fifo_full === 1'b1) begin
            errors++; $display("FAIL rand_write_when_full n=%0d: got wr_en=1 with full=1 want wr_en=0", n);
         end
         checks++;
         if ($countones(ack) > 1) begin errors++; $display("FAIL rand_ack_onehot n=%0d: got %b want <=1 bit", n, ack); end
         checks++;
         if (ack !== e_ack || busy !== m_busy) begin
            errors++; $display("FAIL rand_ack n=%0d: got ack=%b busy=%b want ack=%b busy=%b", n, ack, busy, e_ack, m_busy);
         end
         checks++;
         if (fifo_din !== e_din) begin errors++; $display("FAIL rand_din n=%0d: got %h want %h", n, fifo_din, e_din); end
         next_cycle();
      end
      rst = 1'b1; req = 4'b0000; fifo_full = 1'b0;
      repeat (2) next_cycle();
   endtask

   task automatic test_scoreboard;
      checks++;
      if (sb_bad != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d bad cycles want 0; first at t=%0t ack=%b exp=%b din=%h exp=%h",
                  sb_bad, f_t, f_ack, f_eack, f_din, f_edin);
      end
      checks++;
      if (sb_cycles < 500) begin errors++; $display("FAIL scoreboard_cycles: got %0d want >=500", sb_cycles); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) base[i] = '0;
      rst = 1'b0; req = 4'b0000; fifo_full = 1'b0; seq_clr = 1'b1;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_stall();
      test_early_drop();
      test_reset_mid_burst();
      test_random();
      test_scoreboard();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
